// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin over WIDTH bits using one full-subtractor cell, LSB first.
// Optional SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.  Revision 1.0
`default_nettype none

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             diff;
  logic             brw_next;

  // The single subtractor cell always looks at bit 0 of the operand shifters.
  assign diff     = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_next = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw);
  assign last     = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      brw  <= 1'b0;
      r    <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (load) begin
        a_sh <= a;
        b_sh <= b;
        brw  <= bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r    <= {diff, r[WIDTH-1:1]};
        brw  <= brw_next;
        cnt  <= cnt + CW'(1);
        if (last) begin
          bout <= brw_next;
`ifdef SERIAL_SUB_OVF_EN
          // On the final bit the cell sees the operand MSBs, so no separate capture is needed.
          ovf  <= (a_sh[0] ^ b_sh[0]) & (diff ^ a_sh[0]);
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8) with a queue scoreboard of expected results.
`default_nettype none

module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] r;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ebin);
    exp_t        e;
    logic [W:0]  d;
    d      = {1'b0, ea} - {1'b0, eb} - {{W{1'b0}}, ebin};
    e.r    = d[W-1:0];
    e.bout = d[W];
    e.ovf  = (ea[W-1] != eb[W-1]) && (d[W-1] != ea[W-1]);
    q.push_back(e);
  endtask

  task automatic pulse_start(input logic [W-1:0] pa, input logic [W-1:0] pb, input logic pbin);
    a = pa; b = pb; bin = pbin; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in the first cycle after acceptance; lat counts that cycle as 1.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passed++;
    total++; if (r !== '0) $display("FAIL reset_r got=%h want=00", r); else passed++;
    total++; if (bout !== 1'b0) $display("FAIL reset_bout got=%b want=0", bout); else passed++;
`ifdef SERIAL_SUB_OVF_EN
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf); else passed++;
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [W-1:0] va[4] = '{8'h5A, 8'h00, 8'h10, 8'hFF};
    logic [W-1:0] vb[4] = '{8'h3C, 8'h01, 8'h10, 8'h00};
    logic         vc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat, nb;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      push_exp(va[i], vb[i], vc[i]);
      pulse_start(va[i], vb[i], vc[i]);
      wait_done(lat, nb);
      e = q.pop_front();
      total++; if (lat != 9) $display("FAIL basic%0d_latency got=%0d want=9", i, lat); else passed++;
      total++; if (nb != 8) $display("FAIL basic%0d_busy_cycles got=%0d want=8", i, nb); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL basic%0d_busy_with_done got=%b want=0", i, busy); else passed++;
      total++; if (r !== e.r) $display("FAIL basic%0d_r got=%h want=%h", i, r, e.r); else passed++;
      total++; if (bout !== e.bout) $display("FAIL basic%0d_bout got=%b want=%b", i, bout, e.bout); else passed++;
      step();
      total++; if (done !== 1'b0) $display("FAIL basic%0d_done_width got=%b want=0", i, done); else passed++;
      step(); step();
      total++; if (r !== e.r || bout !== e.bout) $display("FAIL basic%0d_hold got=%h/%b want=%h/%b", i, r, bout, e.r, e.bout); else passed++;
    end
  endtask

  task automatic test_ignore_during_run();
    int lat, ndone;
    exp_t e;
    push_exp(8'h33, 8'h11, 1'b0);
    pulse_start(8'h33, 8'h11, 1'b0);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      start = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    start = 1'b0;
    e = q.pop_front();
    total++; if (lat != 9) $display("FAIL ignore_latency got=%0d want=9", lat); else passed++;
    total++; if (r !== e.r) $display("FAIL ignore_r got=%h want=%h", r, e.r); else passed++;
    total++; if (bout !== e.bout) $display("FAIL ignore_bout got=%b want=%b", bout, e.bout); else passed++;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone != 0) $display("FAIL ignore_extra_done got=%0d want=0", ndone); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    exp_t e;
    push_exp(8'h81, 8'h02, 1'b0);
    pulse_start(8'h81, 8'h02, 1'b0);
    wait_done(lat, nb);
    e = q.pop_front();
    total++; if (r !== e.r) $display("FAIL b2b_first_r got=%h want=%h", r, e.r); else passed++;
    // Held start in the done cycle launches the next operation immediately.
    push_exp(8'hFF, 8'h0F, 1'b0);
    pulse_start(8'hFF, 8'h0F, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy_restart got=%b want=1", busy); else passed++;
    wait_done(lat, nb);
    e = q.pop_front();
    total++; if (lat != 9) $display("FAIL b2b_latency got=%0d want=9", lat); else passed++;
    total++; if (r !== 8'hF0 || r !== e.r) $display("FAIL b2b_r got=%h want=%h", r, e.r); else passed++;
    total++; if (bout !== e.bout) $display("FAIL b2b_bout got=%b want=%b", bout, e.bout); else passed++;
    step(); step();
  endtask

  task automatic test_reset_mid_run();
    int lat, nb;
    exp_t e;
    push_exp(8'h00, 8'h01, 1'b0);
    pulse_start(8'h00, 8'h01, 1'b0);
    wait_done(lat, nb);
    e = q.pop_front();
    total++; if (bout !== e.bout) $display("FAIL rstrun_pre_bout got=%b want=%b", bout, e.bout); else passed++;
    step();
    pulse_start(8'h5A, 8'h3C, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstrun_ctrl got=%b%b want=00", busy, done); else passed++;
    total++; if (r !== '0 || bout !== 1'b0) $display("FAIL rstrun_data got=%h/%b want=00/0", r, bout); else passed++;
    step();
    rst = 1'b0;
    step(); step();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstrun_idle got=%b%b want=00", busy, done); else passed++;
    push_exp(8'hC3, 8'h5A, 1'b1);
    pulse_start(8'hC3, 8'h5A, 1'b1);
    wait_done(lat, nb);
    e = q.pop_front();
    total++; if (lat != 9) $display("FAIL rstrun_latency got=%0d want=9", lat); else passed++;
    total++; if (r !== e.r || bout !== e.bout) $display("FAIL rstrun_result got=%h/%b want=%h/%b", r, bout, e.r, e.bout); else passed++;
    step();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] va[3] = '{8'h80, 8'h05, 8'h7F};
    logic [W-1:0] vb[3] = '{8'h01, 8'h03, 8'hFF};
    int lat, nb;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      push_exp(va[i], vb[i], 1'b0);
      pulse_start(va[i], vb[i], 1'b0);
      wait_done(lat, nb);
      e = q.pop_front();
      total++; if (ovf !== e.ovf) $display("FAIL ovf%0d got=%b want=%b", i, ovf, e.ovf); else passed++;
      total++; if (r !== e.r || bout !== e.bout) $display("FAIL ovf%0d_result got=%h/%b want=%h/%b", i, r, bout, e.r, e.bout); else passed++;
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    total++; if (q.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
